sha_msg_feeder: RTL and testbench

- Host-side initiator for the SHA-512/384 compression core.
- Accepts a byte-aligned message as a stream of 64-bit words and packs 16 words into each 1024-bit block.
- Applies FIPS 180-4 padding and length encoding, drives run/M/H_in into the core, and chains the intermediate hash across blocks.
- Presents the final digest. Sits between the bus/DMA front end and the hashing core.

---
 rtl/sha_msg_feeder.sv | 113 +++++++++++
 tb/tb_sha_msg_feeder.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_msg_feeder.sv
// sha_msg_feeder: packs a byte stream into padded SHA-512/384 blocks and sequences the compression core
module sha_msg_feeder #(
  parameter int LEN_W = 61
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode,
  input  logic [63:0]   msg_data,
  input  logic          msg_valid,
  input  logic          msg_last,
  input  logic [3:0]    msg_bytes,
  output logic          msg_ready,
  output logic [1023:0] core_M,
  output logic [511:0]  core_H_in,
  output logic          core_mode,
  output logic          core_run,
  input  logic          core_ready,
  input  logic          core_done,
  input  logic [511:0]  core_hash,
  output logic [511:0]  digest,
  output logic          digest_valid
);
  localparam logic [511:0] IV512 = {64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b,
    64'ha54ff53a5f1d36f1, 64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
  localparam logic [511:0] IV384 = {64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17,
    64'h152fecd8f70e5939, 64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4};
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, PADX, FIN} state_t;
  state_t state, state_n;
  logic [0:15][63:0] m, blk_n, pad_blk;
  logic [LEN_W-1:0] cnt, cnt_e, cnt_n;
  logic [3:0] wi, wi_e, b;
  logic [4:0] p;
  logic [127:0] len_n, len_q;
  logic [63:0] w;
  logic first, acc, last_blk, pend_pad, pend_80;
  assign first = state == IDLE || state == FIN;
  assign acc = msg_valid && msg_ready;
  assign wi_e = first ? 4'd0 : wi;
  assign cnt_e = first ? '0 : cnt;
  assign b = !msg_last ? 4'd8 : msg_bytes > 4'd8 ? 4'd8 : msg_bytes;
  assign cnt_n = cnt_e + LEN_W'(b);
  assign len_n = 128'({cnt_n, 3'b000});
  assign len_q = 128'({cnt, 3'b000});
  // p is the word that receives the 0x80 marker; 16 means it spills into an extra block
  assign p = 5'(wi_e) + (b == 4'd8 ? 5'd1 : 5'd0);
  assign w = (msg_data & ~(64'hFFFF_FFFF_FFFF_FFFF >> {b, 3'b000})) |
             (b == 4'd8 ? 64'd0 : 64'h80 << {3'd7 - b[2:0], 3'b000});
  assign pad_blk = {pend_80, 895'd0, len_q};
  assign core_M = m;
  assign core_run = state == START && core_ready;
  always_comb begin
    blk_n = m;
    for (int k = 0; k < 16; k++)
      if (4'(k) == wi_e) blk_n[k] = w;
      else if (msg_last && 5'(k) > 5'(wi_e)) blk_n[k] = 5'(k) == p ? 64'h8000_0000_0000_0000 : 64'd0;
    if (msg_last && p <= 5'd13) begin
      blk_n[14] = len_n[127:64];
      blk_n[15] = len_n[63:0];
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE, LOAD, FIN: if (acc) state_n = msg_last || wi_e == 4'd15 ? START : LOAD;
      START:           if (core_ready) state_n = WAIT;
      WAIT:            if (core_done) state_n = last_blk ? FIN : pend_pad ? PADX : LOAD;
      PADX:            state_n = START;
      default:         state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      msg_ready <= 1'b0;
      m <= '0;
      core_H_in <= '0;
      core_mode <= 1'b0;
      cnt <= '0;
      wi <= '0;
      last_blk <= 1'b0;
      pend_pad <= 1'b0;
      pend_80 <= 1'b0;
      digest <= '0;
      digest_valid <= 1'b0;
    end else begin
      state <= state_n;
      msg_ready <= state_n == IDLE || state_n == LOAD || state_n == FIN;
      if (acc) begin
        m <= blk_n;
        cnt <= cnt_n;
        wi <= wi_e + 4'd1;
        last_blk <= msg_last && p <= 5'd13;
        pend_pad <= msg_last && p > 5'd13;
        pend_80 <= msg_last && p == 5'd16;
        if (first) begin
          core_mode <= mode;
          core_H_in <= mode ? IV512 : IV384;
          digest_valid <= 1'b0;
        end
      end
      if (state == WAIT && core_done) begin
        core_H_in <= core_hash;
        if (last_blk) begin
          digest <= core_mode ? core_hash : {core_hash[511:128], 128'd0};
          digest_valid <= 1'b1;
        end else if (pend_pad) begin
          m <= pad_blk;
          last_blk <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_sha_msg_feeder.sv
// tb_sha_msg_feeder: directed tests of block packing, padding, chaining and backpressure against a mock core
module tb_sha_msg_feeder;
  localparam logic [511:0] IV512 = {64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b,
    64'ha54ff53a5f1d36f1, 64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
  localparam logic [511:0] IV384 = {64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17,
    64'h152fecd8f70e5939, 64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4};
  localparam logic [63:0] PAD = 64'h8000_0000_0000_0000;
  logic clk = 1'b0;
  logic rst = 1'b1, mode = 1'b1, msg_valid = 1'b0, msg_last = 1'b0;
  logic core_done = 1'b0, hold = 1'b0, busy = 1'b0;
  logic [63:0] msg_data = '0;
  logic [3:0] msg_bytes = '0;
  logic msg_ready, core_mode, core_run, core_ready, digest_valid;
  logic [1023:0] core_M, mm = '0;
  logic [511:0] core_H_in, digest, core_hash = '0, hh = '0;
  logic [1023:0] cap_m [0:15];
  logic [511:0] cap_h [0:15];
  logic cap_mode [0:15];
  int checks = 0, errors = 0, runs = 0, bad_runs = 0, dly = 0;

  sha_msg_feeder dut (
    .clk(clk), .rst(rst), .mode(mode), .msg_data(msg_data), .msg_valid(msg_valid),
    .msg_last(msg_last), .msg_bytes(msg_bytes), .msg_ready(msg_ready), .core_M(core_M),
    .core_H_in(core_H_in), .core_mode(core_mode), .core_run(core_run), .core_ready(core_ready),
    .core_done(core_done), .core_hash(core_hash), .digest(digest), .digest_valid(digest_valid)
  );

  always #5 clk = ~clk;
  assign core_ready = !busy && !hold;

  // stand-in compression: rotate H and fold in both halves of M, so chaining and block contents both matter
  function automatic logic [511:0] f(input logic [511:0] h, input logic [1023:0] blk);
    return {h[510:0], h[511]} ^ blk[1023:512] ^ blk[511:0];
  endfunction

  function automatic logic [63:0] pat(input int k);
    return 64'h0101_0101_0101_0101 * 64'(k + 1);
  endfunction

  function automatic int first_diff(input logic [0:15][63:0] a, input logic [0:15][63:0] e);
    for (int i = 0; i < 16; i++) if (a[i] !== e[i]) return i;
    return 0;
  endfunction

  always @(posedge clk) begin
    core_done <= 1'b0;
    if (core_run && !core_ready) bad_runs <= bad_runs + 1;
    if (busy) begin
      if (dly == 0) begin
        core_done <= 1'b1;
        core_hash <= f(hh, mm);
        busy <= 1'b0;
      end else dly <= dly - 1;
    end else if (core_run) begin
      busy <= 1'b1;
      dly <= 3;
      mm <= core_M;
      hh <= core_H_in;
      cap_m[4'(runs)] <= core_M;
      cap_h[4'(runs)] <= core_H_in;
      cap_mode[4'(runs)] <= core_mode;
      runs <= runs + 1;
    end
  end

  task automatic put(input logic [63:0] d, input logic l, input logic [3:0] nb);
    int t;
    t = 0;
    @(negedge clk);
    msg_data = d;
    msg_valid = 1'b1;
    msg_last = l;
    msg_bytes = nb;
    while (msg_ready !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      checks++;
      errors++;
      $display("FAIL put_timeout msg_ready=%b required=1", msg_ready);
    end
    @(posedge clk);
    #1;
    msg_valid = 1'b0;
    msg_last = 1'b0;
  endtask

  task automatic wait_digest();
    int t;
    t = 0;
    while (digest_valid !== 1'b1 && t < 300) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (digest_valid !== 1'b1) begin
      errors++;
      $display("FAIL digest_timeout digest_valid=%b required=1", digest_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({msg_ready, core_run, digest_valid, core_mode} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl got=%b required=0000", {msg_ready, core_run, digest_valid, core_mode});
    end
    checks++;
    if (core_M !== '0 || core_H_in !== '0 || digest !== '0) begin
      errors++;
      $display("FAIL reset_data H_in=%h digest=%h required=0", core_H_in, digest);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (msg_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready got=%b required=1", msg_ready);
    end
  endtask

  task automatic test_abc(input logic md);
    int base;
    logic [0:15][63:0] e, g;
    logic [511:0] h, exp, iv;
    base = runs;
    e = '0;
    e[0] = 64'h6162_6380_0000_0000;
    e[15] = 64'h18;
    iv = md ? IV512 : IV384;
    mode = md;
    put(64'h6162_6300_0000_0000, 1'b1, 4'd3);
    checks++;
    if (core_run !== 1'b1 || digest_valid !== 1'b0) begin
      errors++;
      $display("FAIL abc_start run=%b valid=%b required run=1 valid=0", core_run, digest_valid);
    end
    wait_digest();
    h = f(iv, e);
    exp = md ? h : {h[511:128], 128'd0};
    g = cap_m[4'(base)];
    checks++;
    if (runs - base != 1) begin
      errors++;
      $display("FAIL abc_runs got=%0d required=1", runs - base);
    end
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL abc_blk word%0d got=%h required=%h", first_diff(g, e), g[first_diff(g, e)], e[first_diff(g, e)]);
    end
    checks++;
    if (cap_h[4'(base)] !== iv || cap_mode[4'(base)] !== md) begin
      errors++;
      $display("FAIL abc_iv mode=%b H=%h required mode=%b H=%h", cap_mode[4'(base)], cap_h[4'(base)], md, iv);
    end
    checks++;
    if (digest !== exp) begin
      errors++;
      $display("FAIL abc_digest got=%h required=%h", digest, exp);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (digest !== exp || digest_valid !== 1'b1 || msg_ready !== 1'b1) begin
      errors++;
      $display("FAIL abc_hold valid=%b ready=%b digest=%h required=%h", digest_valid, msg_ready, digest, exp);
    end
  endtask

  task automatic test_msg(input string name, input int nw, input logic [3:0] lb, input int nb,
                          input logic [0:15][63:0] e1, input logic [0:15][63:0] e2,
                          input bit gap, input int hold_cycles);
    int base, hi;
    logic [0:15][63:0] g;
    logic [511:0] h1, exp;
    base = runs;
    mode = 1'b1;
    hold = hold_cycles > 0;
    for (int k = 0; k < nw; k++) begin
      put(pat(k), k == nw - 1, k == nw - 1 ? lb : 4'd8);
      if (k == 0) mode = 1'b0;
      if (gap && k % 3 == 1) repeat (2) @(negedge clk);
      if (hold && k == 15) begin
        hi = 0;
        repeat (hold_cycles) begin
          @(negedge clk);
          hi += int'(core_run);
        end
        checks++;
        if (hi != 0 || runs != base || msg_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s_held runs=%0d pulses=%0d ready=%b required 0 0 0", name, runs - base, hi, msg_ready);
        end
        hold = 1'b0;
        #1;
        checks++;
        if (core_run !== 1'b1) begin
          errors++;
          $display("FAIL %s_release core_run=%b required=1", name, core_run);
        end
      end
    end
    wait_digest();
    checks++;
    if (runs - base != nb) begin
      errors++;
      $display("FAIL %s_runs got=%0d required=%0d", name, runs - base, nb);
    end
    checks++;
    if (cap_h[4'(base)] !== IV512 || cap_mode[4'(base)] !== 1'b1) begin
      errors++;
      $display("FAIL %s_iv mode=%b H=%h required mode=1 H=%h", name, cap_mode[4'(base)], cap_h[4'(base)], IV512);
    end
    g = cap_m[4'(base)];
    checks++;
    if (g !== e1) begin
      errors++;
      $display("FAIL %s_blk1 word%0d got=%h required=%h", name, first_diff(g, e1), g[first_diff(g, e1)], e1[first_diff(g, e1)]);
    end
    h1 = f(IV512, e1);
    exp = h1;
    if (nb == 2) begin
      g = cap_m[4'(base + 1)];
      checks++;
      if (g !== e2) begin
        errors++;
        $display("FAIL %s_blk2 word%0d got=%h required=%h", name, first_diff(g, e2), g[first_diff(g, e2)], e2[first_diff(g, e2)]);
      end
      checks++;
      if (cap_h[4'(base + 1)] !== h1) begin
        errors++;
        $display("FAIL %s_chain got=%h required=%h", name, cap_h[4'(base + 1)], h1);
      end
      exp = f(h1, e2);
    end
    checks++;
    if (digest !== exp) begin
      errors++;
      $display("FAIL %s_digest got=%h required=%h", name, digest, exp);
    end
    checks++;
    if (bad_runs != 0) begin
      errors++;
      $display("FAIL %s_run_not_ready got=%0d required=0", name, bad_runs);
    end
  endtask

  task automatic test_empty();
    logic [0:15][63:0] e1;
    e1 = '0;
    e1[0] = PAD;
    test_msg("empty", 1, 4'd0, 1, e1, '0, 1'b0, 0);
  endtask

  task automatic test_111();
    logic [0:15][63:0] e1;
    e1 = '0;
    for (int k = 0; k < 13; k++) e1[k] = pat(k);
    e1[13] = 64'h0e0e_0e0e_0e0e_0e80;
    e1[15] = 64'h378;
    test_msg("len111", 14, 4'd7, 1, e1, '0, 1'b0, 0);
  endtask

  task automatic test_112();
    logic [0:15][63:0] e1, e2;
    e1 = '0;
    e2 = '0;
    for (int k = 0; k < 14; k++) e1[k] = pat(k);
    e1[14] = PAD;
    e2[15] = 64'h380;
    test_msg("len112", 14, 4'd8, 2, e1, e2, 1'b0, 0);
  endtask

  task automatic test_128();
    logic [0:15][63:0] e1, e2;
    e2 = '0;
    for (int k = 0; k < 16; k++) e1[k] = pat(k);
    e2[0] = PAD;
    e2[15] = 64'h400;
    test_msg("len128", 16, 4'd8, 2, e1, e2, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    logic [0:15][63:0] e1, e2;
    e2 = '0;
    for (int k = 0; k < 16; k++) e1[k] = pat(k);
    for (int k = 0; k < 9; k++) e2[k] = pat(k + 16);
    e2[9] = PAD;
    e2[15] = 64'h640;
    test_msg("len200", 25, 4'd8, 2, e1, e2, 1'b1, 10);
  endtask

  task automatic test_rst_wait();
    int base;
    base = runs;
    mode = 1'b1;
    put(64'h6162_6300_0000_0000, 1'b1, 4'd3);
    @(posedge clk);
    #1;
    checks++;
    if (runs - base != 1 || msg_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_inflight runs=%0d ready=%b required runs=1 ready=0", runs - base, msg_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if ({msg_ready, core_run, digest_valid, core_mode} !== 4'b0000 || core_M !== '0 || core_H_in !== '0) begin
      errors++;
      $display("FAIL rst_wait ctrl=%b H_in=%h required ctrl=0000 H_in=0", {msg_ready, core_run, digest_valid, core_mode}, core_H_in);
    end
    repeat (12) @(negedge clk);
    checks++;
    if (digest_valid !== 1'b0 || digest !== '0 || msg_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_late_done valid=%b ready=%b digest=%h required valid=0 ready=1 digest=0", digest_valid, msg_ready, digest);
    end
    test_abc(1'b1);
  endtask

  initial begin
    test_reset();
    test_abc(1'b1);
    test_abc(1'b0);
    test_empty();
    test_111();
    test_112();
    test_128();
    test_back_to_back();
    test_rst_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end
endmodule
